// File: rtl/raisin64_pkg.sv
// ---------------------------------------------------------------------------
// raisin64_pkg
// Shared definitions for the raisin64 execute stage: datapath widths, the
// memory-op bit positions decoded by the load/store unit, and the load/store
// unit FSM state encoding.
// ---------------------------------------------------------------------------
package raisin64_pkg;

    localparam int XLEN = 64;
    localparam int RN_W = 6;

    // Bit positions inside the 2-bit memory op field
    localparam int MEM_OP_STORE = 0;
    localparam int MEM_OP_W32   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RESULT = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
// Combinational lane logic for the load/store unit.
//   ea_lo      in  3   low bits of the effective address
//   op         in  2   memory op (store / 32-bit flags)
//   store_data in  64  raw store register value
//   rdata      in  64  doubleword read from the data bus
//   be         out 8   byte enables for the access
//   wdata      out 64  store data placed in the correct lane(s)
//   misalign   out 1   access is not naturally aligned
//   load_data  out 64  extracted, sign-extended load value
// ---------------------------------------------------------------------------
module mem_align
    import raisin64_pkg::*;
(
    input  logic [2:0]      ea_lo,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic            misalign,
    output logic [XLEN-1:0] load_data
);

    logic [31:0] word;

    // A 32-bit store drives the word on both halves so the memory only needs
    // the byte enables to pick the lane.
    always_comb begin
        word      = ea_lo[2] ? rdata[63:32] : rdata[31:0];
        be        = 8'hFF;
        wdata     = store_data;
        misalign  = (ea_lo != 3'b000);
        load_data = rdata;
        if (op[MEM_OP_W32]) begin
            be        = ea_lo[2] ? 8'hF0 : 8'h0F;
            wdata     = {2{store_data[31:0]}};
            misalign  = (ea_lo[1:0] != 2'b00);
            load_data = {{32{word[31]}}, word};
        end
    end

endmodule

// File: rtl/ex_memunit.sv
// ---------------------------------------------------------------------------
// ex_memunit
// Load/store execution unit. One memory instruction at a time is issued by
// the scheduler, runs a single request/acknowledge transaction on the data
// bus, and (for loads or faults) presents its result to commit through the
// valid/stall handshake. All outputs are registered.
//   clk, rst_n                 clock, async active-low reset
//   ex_enable / ex_busy        issue handshake with the scheduler
//   op, in1, in2, imm, rd_in_rn  instruction operands
//   out, rd_out_rn, valid, misalign, stall   result handshake with commit
//   dmem_*                     data memory bus
// ---------------------------------------------------------------------------
module ex_memunit
    import raisin64_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_enable,
    output logic            ex_busy,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [XLEN-1:0] imm,
    input  logic [RN_W-1:0] rd_in_rn,
    output logic [XLEN-1:0] out,
    output logic [RN_W-1:0] rd_out_rn,
    output logic            valid,
    input  logic            stall,
    output logic            misalign,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_be,
    output logic            dmem_we,
    output logic            dmem_addr_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_data_valid
);

    mem_state_t      state;
    logic [1:0]      op_q;
    logic [2:0]      ea_lo_q;
    logic [RN_W-1:0] rd_q;

    logic [XLEN-1:0] ea;
    logic [2:0]      align_ea_lo;
    logic [1:0]      align_op;
    logic [7:0]      align_be;
    logic [XLEN-1:0] align_wdata;
    logic            align_mis;
    logic [XLEN-1:0] align_load;

    assign ea = in1 + imm;

    // One aligner serves both phases: at issue it sees the incoming access,
    // afterwards it sees the latched lane/op so read data can be extracted.
    assign align_ea_lo = (state == ST_IDLE) ? ea[2:0] : ea_lo_q;
    assign align_op    = (state == ST_IDLE) ? op      : op_q;

    mem_align u_align (
        .ea_lo      (align_ea_lo),
        .op         (align_op),
        .store_data (in2),
        .rdata      (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .misalign   (align_mis),
        .load_data  (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            op_q            <= 2'b00;
            ea_lo_q         <= 3'b000;
            rd_q            <= '0;
            ex_busy         <= 1'b0;
            valid           <= 1'b0;
            misalign        <= 1'b0;
            out             <= '0;
            rd_out_rn       <= '0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_be         <= 8'h00;
            dmem_we         <= 1'b0;
            dmem_addr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ex_enable) begin
                        ex_busy <= 1'b1;
                        op_q    <= op;
                        ea_lo_q <= ea[2:0];
                        rd_q    <= rd_in_rn;
                        if (align_mis) begin
                            // Faulting access reports the address instead of data
                            state     <= ST_RESULT;
                            valid     <= 1'b1;
                            misalign  <= 1'b1;
                            out       <= ea;
                            rd_out_rn <= '0;
                        end else begin
                            state           <= ST_REQ;
                            dmem_addr       <= {ea[XLEN-1:3], 3'b000};
                            dmem_wdata      <= align_wdata;
                            dmem_be         <= align_be;
                            dmem_we         <= op[MEM_OP_STORE];
                            dmem_addr_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_data_valid) begin
                        dmem_addr_valid <= 1'b0;
                        dmem_we         <= 1'b0;
                        if (op_q[MEM_OP_STORE]) begin
                            state   <= ST_IDLE;
                            ex_busy <= 1'b0;
                        end else begin
                            state     <= ST_RESULT;
                            valid     <= 1'b1;
                            misalign  <= 1'b0;
                            out       <= align_load;
                            rd_out_rn <= rd_q;
                        end
                    end
                end
                ST_RESULT: begin
                    if (!stall) begin
                        state    <= ST_IDLE;
                        valid    <= 1'b0;
                        misalign <= 1'b0;
                        ex_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ex_busy <= 1'b0;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_memunit.sv
// ---------------------------------------------------------------------------
// tb_ex_memunit
// Self-checking bench for ex_memunit: a table of load/store vectors run
// back-to-back, a scoreboard of expected results compared whenever commit
// consumes a result, plus hand-written backpressure and reset sequences.
// ---------------------------------------------------------------------------
module tb_ex_memunit;

    localparam logic [1:0] OP_LD64 = 2'b00;
    localparam logic [1:0] OP_ST64 = 2'b01;
    localparam logic [1:0] OP_LD32 = 2'b10;
    localparam logic [1:0] OP_ST32 = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        ex_enable;
    logic        ex_busy;
    logic [1:0]  op;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] imm;
    logic [5:0]  rd_in_rn;
    logic [63:0] out;
    logic [5:0]  rd_out_rn;
    logic        valid;
    logic        stall;
    logic        misalign;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_we;
    logic        dmem_addr_valid;
    logic [63:0] dmem_rdata;
    logic        dmem_data_valid;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [63:0] in1;
        logic [63:0] imm;
        logic [63:0] in2;
        logic [5:0]  rd;
        logic [63:0] rdata;
        int          waits;
        logic [63:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic        e_mis;
        logic [63:0] e_out;
        logic [5:0]  e_rd;
    } vec_t;

    typedef struct {
        logic [63:0] out;
        logic [5:0]  rd;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   checks;
    int   failures;

    ex_memunit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_enable       (ex_enable),
        .ex_busy         (ex_busy),
        .op              (op),
        .in1             (in1),
        .in2             (in2),
        .imm             (imm),
        .rd_in_rn        (rd_in_rn),
        .out             (out),
        .rd_out_rn       (rd_out_rn),
        .valid           (valid),
        .stall           (stall),
        .misalign        (misalign),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .dmem_we         (dmem_we),
        .dmem_addr_valid (dmem_addr_valid),
        .dmem_rdata      (dmem_rdata),
        .dmem_data_valid (dmem_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%016h required=0x%016h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(string name, logic [1:0] vop, logic [63:0] vin1, logic [63:0] vimm,
                                   logic [63:0] vin2, logic [5:0] vrd, logic [63:0] vrdata, int vwaits,
                                   logic [63:0] e_addr, logic [7:0] e_be, logic [63:0] e_wdata,
                                   logic e_mis, logic [63:0] e_out, logic [5:0] e_rd);
        vec_t v;
        v.name = name; v.op = vop; v.in1 = vin1; v.imm = vimm; v.in2 = vin2;
        v.rd = vrd; v.rdata = vrdata; v.waits = vwaits; v.e_addr = e_addr;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_mis = e_mis; v.e_out = e_out; v.e_rd = e_rd;
        return v;
    endfunction

    // Called just after a falling edge; returns just after the next one,
    // i.e. after the issue edge. Operands are scrambled afterwards so any
    // failure to latch them shows up.
    task automatic applyStimulus(input vec_t v, input bit track);
        op        = v.op;
        in1       = v.in1;
        in2       = v.in2;
        imm       = v.imm;
        rd_in_rn  = v.rd;
        ex_enable = 1'b1;
        if (track && (v.e_mis || !v.op[0]))
            sb.push_back('{out: v.e_out, rd: v.e_rd, mis: v.e_mis});
        @(negedge clk);
        ex_enable = 1'b0;
        op        = 2'($urandom_range(0, 3));
        in1       = {$urandom, $urandom};
        in2       = {$urandom, $urandom};
        imm       = {$urandom, $urandom};
        rd_in_rn  = 6'($urandom_range(0, 63));
    endtask

    task automatic runVector(input vec_t v);
        checkOutput({v.name, "_idle_busy"}, 64'(ex_busy), 64'd0);
        applyStimulus(v, 1'b1);
        if (v.e_mis) begin
            checkOutput({v.name, "_valid"},     64'(valid),           64'd1);
            checkOutput({v.name, "_misalign"},  64'(misalign),        64'd1);
            checkOutput({v.name, "_no_req"},    64'(dmem_addr_valid), 64'd0);
            checkOutput({v.name, "_busy"},      64'(ex_busy),         64'd1);
            @(negedge clk);
            checkOutput({v.name, "_valid_off"}, 64'(valid),           64'd0);
            checkOutput({v.name, "_done_busy"}, 64'(ex_busy),         64'd0);
        end else begin
            checkOutput({v.name, "_req"},   64'(dmem_addr_valid), 64'd1);
            checkOutput({v.name, "_addr"},  dmem_addr,            v.e_addr);
            checkOutput({v.name, "_be"},    64'(dmem_be),         64'(v.e_be));
            checkOutput({v.name, "_we"},    64'(dmem_we),         64'(v.op[0]));
            checkOutput({v.name, "_valid"}, 64'(valid),           64'd0);
            if (v.op[0])
                checkOutput({v.name, "_wdata"}, dmem_wdata, v.e_wdata);
            for (int w = 0; w < v.waits; w++) begin
                @(negedge clk);
                checkOutput({v.name, "_hold_req"},  64'(dmem_addr_valid), 64'd1);
                checkOutput({v.name, "_hold_addr"}, dmem_addr,            v.e_addr);
                checkOutput({v.name, "_hold_be"},   64'(dmem_be),         64'(v.e_be));
                checkOutput({v.name, "_hold_we"},   64'(dmem_we),         64'(v.op[0]));
                if (v.op[0])
                    checkOutput({v.name, "_hold_wdata"}, dmem_wdata, v.e_wdata);
                checkOutput({v.name, "_hold_valid"}, 64'(valid), 64'd0);
            end
            dmem_rdata      = v.rdata;
            dmem_data_valid = 1'b1;
            @(negedge clk);
            dmem_data_valid = 1'b0;
            dmem_rdata      = {$urandom, $urandom};
            checkOutput({v.name, "_req_off"}, 64'(dmem_addr_valid), 64'd0);
            if (v.op[0]) begin
                checkOutput({v.name, "_st_busy"},  64'(ex_busy), 64'd0);
                checkOutput({v.name, "_st_valid"}, 64'(valid),   64'd0);
            end else begin
                checkOutput({v.name, "_ld_valid"}, 64'(valid),    64'd1);
                checkOutput({v.name, "_ld_mis"},   64'(misalign), 64'd0);
                checkOutput({v.name, "_ld_busy"},  64'(ex_busy),  64'd1);
                @(negedge clk);
                checkOutput({v.name, "_valid_off"}, 64'(valid),   64'd0);
                checkOutput({v.name, "_done_busy"}, 64'(ex_busy), 64'd0);
            end
        end
    endtask

    // Sampled just after the falling edge, so valid/stall are the values the
    // next rising edge will see: a result consumed there is compared here.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (ex_enable) begin
                assert (!ex_busy) else begin
                    failures++;
                    $display("[TB] FAIL issue_while_busy actual=1 required=0");
                end
            end
            if (valid && !stall) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_unexpected actual out=0x%016h rd=%0d required no result", out, rd_out_rn);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("sb_out",      out,                e.out);
                    checkOutput("sb_rd",       64'(rd_out_rn),     64'(e.rd));
                    checkOutput("sb_misalign", 64'(misalign),      64'(e.mis));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t  sv;
        logic [63:0] held_out;
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        ex_enable       = 1'b0;
        op              = 2'b00;
        in1             = '0;
        in2             = '0;
        imm             = '0;
        rd_in_rn        = '0;
        stall           = 1'b0;
        dmem_rdata      = '0;
        dmem_data_valid = 1'b0;

        vecs[0]  = mkVec("ld64_basic",  OP_LD64, 64'h1000, 64'h8, 64'h0, 6'd5, 64'hDEADBEEF_CAFEF00D, 0,
                         64'h1008, 8'hFF, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 6'd5);
        vecs[1]  = mkVec("ld32_hi_neg", OP_LD32, 64'h2000, 64'h4, 64'h0, 6'd7, 64'h80000001_00000000, 0,
                         64'h2000, 8'hF0, 64'h0, 1'b0, 64'hFFFFFFFF_80000001, 6'd7);
        vecs[2]  = mkVec("st32_wait3",  OP_ST32, 64'h310, 64'hFFFFFFFF_FFFFFFF0, 64'hAABBCCDD_11223344, 6'd1, 64'h0, 3,
                         64'h300, 8'h0F, 64'h11223344_11223344, 1'b0, 64'h0, 6'd0);
        vecs[3]  = mkVec("ld64_misal",  OP_LD64, 64'h1000, 64'h4, 64'h0, 6'd9, 64'h0, 0,
                         64'h0, 8'h00, 64'h0, 1'b1, 64'h1004, 6'd0);
        vecs[4]  = mkVec("ld32_lo_pos", OP_LD32, 64'h4000, 64'h0, 64'h0, 6'd12, 64'hFFFFFFFF_7FFFFFFF, 1,
                         64'h4000, 8'h0F, 64'h0, 1'b0, 64'h00000000_7FFFFFFF, 6'd12);
        vecs[5]  = mkVec("st64_wait2",  OP_ST64, 64'h5000, 64'h8, 64'h01234567_89ABCDEF, 6'd2, 64'h0, 2,
                         64'h5008, 8'hFF, 64'h01234567_89ABCDEF, 1'b0, 64'h0, 6'd0);
        vecs[6]  = mkVec("st32_hi",     OP_ST32, 64'h600, 64'h4, 64'h00000000_CAFEBABE, 6'd3, 64'h0, 0,
                         64'h600, 8'hF0, 64'hCAFEBABE_CAFEBABE, 1'b0, 64'h0, 6'd0);
        vecs[7]  = mkVec("ld64_rd0",    OP_LD64, 64'h700, 64'h0, 64'h0, 6'd0, 64'h55, 0,
                         64'h700, 8'hFF, 64'h0, 1'b0, 64'h55, 6'd0);
        vecs[8]  = mkVec("ld32_misal",  OP_LD32, 64'h800, 64'h2, 64'h0, 6'd4, 64'h0, 0,
                         64'h0, 8'h00, 64'h0, 1'b1, 64'h802, 6'd0);
        vecs[9]  = mkVec("st64_misal",  OP_ST64, 64'h900, 64'h4, 64'h1, 6'd0, 64'h0, 0,
                         64'h0, 8'h00, 64'h0, 1'b1, 64'h904, 6'd0);
        vecs[10] = mkVec("ld32_hi_pos", OP_LD32, 64'hA00, 64'h4, 64'h0, 6'd33, 64'h12345678_9ABCDEF0, 0,
                         64'hA00, 8'hF0, 64'h0, 1'b0, 64'h00000000_12345678, 6'd33);
        vecs[11] = mkVec("ld64_wrap",   OP_LD64, 64'hFFFFFFFF_FFFFFFF8, 64'h10, 64'h0, 6'd63, 64'h0F0F0F0F_F0F0F0F0, 1,
                         64'h8, 8'hFF, 64'h0, 1'b0, 64'h0F0F0F0F_F0F0F0F0, 6'd63);
        vecs[12] = mkVec("ld32_lo_neg", OP_LD32, 64'hC08, 64'h0, 64'h0, 6'd20, 64'h00000000_80000000, 0,
                         64'hC08, 8'h0F, 64'h0, 1'b0, 64'hFFFFFFFF_80000000, 6'd20);
        vecs[13] = mkVec("st32_misal",  OP_ST32, 64'hD00, 64'h6, 64'h77, 6'd0, 64'h0, 0,
                         64'h0, 8'h00, 64'h0, 1'b1, 64'hD06, 6'd0);

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",  64'(ex_busy),         64'd0);
        checkOutput("rst_valid", 64'(valid),           64'd0);
        checkOutput("rst_req",   64'(dmem_addr_valid), 64'd0);
        checkOutput("rst_out",   out,                  64'd0);
        checkOutput("rst_addr",  dmem_addr,            64'd0);
        checkOutput("rst_be",    64'(dmem_be),         64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back as soon as the unit frees up
        for (int i = 0; i < 14; i++)
            runVector(vecs[i]);

        // Commit backpressure: result must hold for 5 stalled cycles
        stall = 1'b1;
        sv = mkVec("ld64_stall", OP_LD64, 64'h1010, 64'h0, 64'h0, 6'd3, 64'h13572468_ACEBDF00, 0,
                   64'h1010, 8'hFF, 64'h0, 1'b0, 64'h13572468_ACEBDF00, 6'd3);
        held_out = 64'h13572468_ACEBDF00;
        applyStimulus(sv, 1'b1);
        dmem_rdata      = sv.rdata;
        dmem_data_valid = 1'b1;
        @(negedge clk);
        dmem_data_valid = 1'b0;
        checkOutput("stall_valid0", 64'(valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_valid", 64'(valid),     64'd1);
            checkOutput("stall_out",   out,            held_out);
            checkOutput("stall_rd",    64'(rd_out_rn), 64'd3);
            checkOutput("stall_busy",  64'(ex_busy),   64'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        checkOutput("stall_release_valid", 64'(valid),   64'd0);
        checkOutput("stall_release_busy",  64'(ex_busy), 64'd0);

        // Reset during REQ, then a late acknowledge that must be ignored
        sv = mkVec("ld64_abort", OP_LD64, 64'h2000, 64'h0, 64'h0, 6'd8, 64'h0, 0,
                   64'h2000, 8'hFF, 64'h0, 1'b0, 64'h0, 6'd0);
        applyStimulus(sv, 1'b0);
        checkOutput("abort_req", 64'(dmem_addr_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy",  64'(ex_busy),         64'd0);
        checkOutput("abort_valid", 64'(valid),           64'd0);
        checkOutput("abort_req0",  64'(dmem_addr_valid), 64'd0);
        checkOutput("abort_we",    64'(dmem_we),         64'd0);
        checkOutput("abort_mis",   64'(misalign),        64'd0);
        checkOutput("abort_out",   out,                  64'd0);
        checkOutput("abort_rd",    64'(rd_out_rn),       64'd0);
        checkOutput("abort_addr",  dmem_addr,            64'd0);
        checkOutput("abort_wdata", dmem_wdata,           64'd0);
        checkOutput("abort_be",    64'(dmem_be),         64'd0);
        @(negedge clk);
        rst_n           = 1'b1;
        dmem_rdata      = 64'hFFFF_0000_FFFF_0000;
        dmem_data_valid = 1'b1;
        @(negedge clk);
        dmem_data_valid = 1'b0;
        checkOutput("late_ack_valid", 64'(valid),           64'd0);
        checkOutput("late_ack_busy",  64'(ex_busy),         64'd0);
        checkOutput("late_ack_req",   64'(dmem_addr_valid), 64'd0);
        runVector(vecs[0]);
        runVector(vecs[2]);

        @(negedge clk);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
